ram_burst_master: RTL and testbench

//  Initiator side of the single-port synchronous RAM interface (data_in/addr/mode/data_out, mode=1 write).

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_burst_master_if.sv | 44 ++++
 rtl/ram_burst_master.sv | 92 +++++++++
 tb/tb_ram_burst_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the burst master and the single-port RAM it drives.
package ram_pkg;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;

  localparam logic MODE_WRITE = 1'b1;
  localparam logic MODE_READ  = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;
endpackage

// File: rtl/ram_burst_master_if.sv
// Client command/stream port plus RAM-side port of the burst master.
// chk_out exists only when BURST_CHECKSUM_EN is defined.
interface ram_burst_master_if #(
  parameter int ADDR_W = ram_pkg::DEF_ADDR_W,
  parameter int DATA_W = ram_pkg::DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              done;
  logic              busy;
  logic [DATA_W-1:0] ram_data_in;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_mode;
  logic [DATA_W-1:0] ram_data_out;
`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] chk_out;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, ram_data_out,
    output cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           ram_data_in, ram_addr, ram_mode
`ifdef BURST_CHECKSUM_EN
    , output chk_out
`endif
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, ram_data_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid, done, busy,
           ram_data_in, ram_addr, ram_mode
`ifdef BURST_CHECKSUM_EN
    , input chk_out
`endif
  );
endinterface

// File: rtl/ram_burst_master.sv
// Burst initiator for a single-port synchronous RAM with 1-cycle read latency.
// Optional per-burst XOR checksum on chk_out when BURST_CHECKSUM_EN is defined.
module ram_burst_master
  import ram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clk,
  input  logic                rst,
  ram_burst_master_if.master  bus
);
  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, cnt;
  logic              rd_pending, done_q;
  logic [DATA_W-1:0] rd_word;

  logic accept, wr_hs, step, last;
  assign accept  = (state == IDLE) && bus.cmd_valid;
  assign wr_hs   = (state == WRITE) && bus.wr_valid;
  assign step    = wr_hs || (state == READ);
  assign last    = (cnt == '0);
  assign rd_word = bus.ram_data_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.cmd_ready   = 1'b0;
    bus.wr_ready    = 1'b0;
    bus.busy        = 1'b1;
    bus.ram_mode    = MODE_READ;
    bus.ram_addr    = addr;
    bus.ram_data_in = bus.wr_data;
    bus.rd_data     = rd_word;
    bus.rd_valid    = rd_pending;
    bus.done        = done_q;
    unique case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        bus.busy      = 1'b0;
        if (bus.cmd_valid) state_nxt = bus.cmd_write ? WRITE : READ;
      end
      WRITE: begin
        bus.wr_ready = 1'b1;
        bus.ram_mode = bus.wr_valid ? MODE_WRITE : MODE_READ;
        if (bus.wr_valid && last) state_nxt = IDLE;
      end
      READ: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address wraps naturally at 2**ADDR_W; cnt counts remaining beats minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr       <= '0;
      cnt        <= '0;
      rd_pending <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_pending <= (state == READ);
      done_q     <= step && last;
      if (accept) begin
        addr <= bus.cmd_addr;
        cnt  <= bus.cmd_len;
      end else if (step) begin
        addr <= addr + 1'b1;
        cnt  <= cnt - 1'b1;
      end
    end
  end

`ifdef BURST_CHECKSUM_EN
  logic [DATA_W-1:0] chk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             chk <= '0;
    else if (accept)     chk <= '0;
    else if (wr_hs)      chk <= chk ^ bus.wr_data;
    else if (rd_pending) chk <= chk ^ rd_word;
  end

  // Fold in the word arriving this cycle so the final read beat counts in the done cycle.
  assign bus.chk_out = rd_pending ? (chk ^ rd_word) : chk;
`endif
endmodule

// File: tb/tb_ram_burst_master.sv
// Directed plus randomized bursts against a behavioural RAM and a reference memory image.
module tb_ram_burst_master;
  import ram_pkg::*;

  localparam int AW    = DEF_ADDR_W;
  localparam int DW    = DEF_DATA_W;
  localparam int DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_burst_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ram_burst_master #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Single-port RAM with registered read data (read-before-write).
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (bus.ram_mode == MODE_WRITE) ram[bus.ram_addr] <= bus.ram_data_in;
    bus.ram_data_out <= ram[bus.ram_addr];
  end

  logic [DW-1:0] ref_mem [DEPTH];
  int checks = 0, errors = 0;

  bit            tail_done, tail_rd;
  logic [DW-1:0] tail_rd_data;
`ifdef BURST_CHECKSUM_EN
  logic [DW-1:0] tail_chk;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic noise();
    bus.cmd_valid = 1'($urandom_range(0, 1));
    bus.cmd_write = 1'($urandom_range(0, 1));
    bus.cmd_addr  = AW'($urandom);
    bus.cmd_len   = AW'($urandom);
  endtask

  // Outputs expected in the cycle after a burst ends (done pulse, final read word).
  task automatic check_tail();
    check("done", bus.done, tail_done);
    check("tail_rd_valid", bus.rd_valid, tail_rd);
    if (tail_rd) check("tail_rd_data", bus.rd_data, tail_rd_data);
`ifdef BURST_CHECKSUM_EN
    if (tail_done) check("chk_done", bus.chk_out, tail_chk);
`endif
    tail_done = 0;
    tail_rd   = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'($urandom_range(0, 1));
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);
    check("idle_busy", bus.busy, 0);
    check("idle_wr_ready", bus.wr_ready, 0);
    check("idle_ram_mode", bus.ram_mode, 0);
    check_tail();
  endtask

  task automatic start_cmd(input bit wr, input int a, input int len);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = AW'(a);
    bus.cmd_len   = AW'(len);
    bus.wr_valid  = 1'b0;
    #1;
    check("accept_cmd_ready", bus.cmd_ready, 1);
    check("accept_busy", bus.busy, 0);
    check_tail();
  endtask

  // mode 0: wr_valid always high; 1: pattern 1,0,0 repeating; 2: random with bounded stalls
  task automatic write_burst(input int a, input int len, input int mode, input logic [DW-1:0] d[$]);
    int addr = a, beats = 0, cyc = 0, stalls = 0;
    logic v;
`ifdef BURST_CHECKSUM_EN
    logic [DW-1:0] x = '0;
`endif
    start_cmd(1'b1, a, len);
    while (beats <= len) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3 == 0);
        default: v = (stalls >= 4) || ($urandom_range(0, 1) == 1);
      endcase
      stalls       = v ? 0 : stalls + 1;
      bus.wr_valid = v;
      bus.wr_data  = d[beats];
      noise();
      #1;
      check("wr_ready", bus.wr_ready, 1);
      check("wr_busy", bus.busy, 1);
      check("wr_cmd_ready", bus.cmd_ready, 0);
      check("wr_ram_mode", bus.ram_mode, v);
      check("wr_addr", bus.ram_addr, addr);
      check("wr_data_in", bus.ram_data_in, d[beats]);
      check("wr_done", bus.done, 0);
      if (v) begin
        ref_mem[addr] = d[beats];
`ifdef BURST_CHECKSUM_EN
        x ^= d[beats];
`endif
        addr = (addr + 1) % DEPTH;
        beats++;
      end
      cyc++;
    end
    tail_done = 1;
`ifdef BURST_CHECKSUM_EN
    tail_chk = x;
`endif
  endtask

  task automatic read_burst(input int a, input int len);
`ifdef BURST_CHECKSUM_EN
    logic [DW-1:0] x = '0;
`endif
    start_cmd(1'b0, a, len);
    for (int i = 0; i <= len; i++) begin
      @(negedge clk);
      bus.wr_valid = 1'($urandom_range(0, 1));
      noise();
      #1;
      check("rd_ram_mode", bus.ram_mode, 0);
      check("rd_wr_ready", bus.wr_ready, 0);
      check("rd_busy", bus.busy, 1);
      check("rd_cmd_ready", bus.cmd_ready, 0);
      check("rd_done", bus.done, 0);
      check("rd_addr", bus.ram_addr, (a + i) % DEPTH);
      check("rd_valid", bus.rd_valid, i > 0);
      if (i > 0) check("rd_data", bus.rd_data, ref_mem[(a + i - 1) % DEPTH]);
`ifdef BURST_CHECKSUM_EN
      x ^= ref_mem[(a + i) % DEPTH];
`endif
    end
    tail_done    = 1;
    tail_rd      = 1;
    tail_rd_data = ref_mem[(a + len) % DEPTH];
`ifdef BURST_CHECKSUM_EN
    tail_chk = x;
`endif
  endtask

  function automatic void rand_data(ref logic [DW-1:0] q[$], input int n);
    q.delete();
    for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
  endfunction

  initial begin
    logic [DW-1:0] q[$];
    logic [DW-1:0] v;
    rst = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_data   = '0;
    bus.wr_valid  = 1'b1;
    tail_done = 0;
    tail_rd   = 0;
    for (int i = 0; i < DEPTH; i++) begin
      v          = DW'($urandom);
      ram[i]    <= v;
      ref_mem[i] = v;
    end

    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ram_mode", bus.ram_mode, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_done", bus.done, 0);
`ifdef BURST_CHECKSUM_EN
    check("rst_chk", bus.chk_out, 0);
`endif
    @(negedge clk);
    rst = 1'b0;
    idle_cycle();

    // Basic write then back-to-back read of the same words
    q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    write_burst(5, 3, 0, q);
    read_burst(5, 3);
    idle_cycle();

    // Wrap across the top of the address space
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    write_burst(62, 3, 0, q);
    idle_cycle();
    read_burst(62, 3);
    idle_cycle();

    // Stalled write stream
    rand_data(q, 6);
    write_burst(30, 5, 1, q);
    read_burst(30, 5);
    idle_cycle();

    // Reset during the second beat of a 4-word write
    start_cmd(1'b1, 20, 3);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_data   = 8'h77;
    #1;
    check("rw_mode_beat1", bus.ram_mode, 1);
    ref_mem[20] = 8'h77;
    @(negedge clk);
    bus.wr_data = 8'h88;
    #1;
    check("rw_mode_beat2", bus.ram_mode, 1);
    check("rw_addr_beat2", bus.ram_addr, 21);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_ram_mode", bus.ram_mode, 0);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_wr_ready", bus.wr_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    check("rst_rel_cmd_ready", bus.cmd_ready, 1);
    check("rst_rel_done", bus.done, 0);
    tail_done = 0;
    idle_cycle();
    read_burst(20, 3);
    idle_cycle();

    // Checksum-oriented bursts
    q = '{8'h0F, 8'hF0, 8'hFF};
    write_burst(40, 2, 0, q);
    q = '{8'h5A};
    write_burst(50, 0, 0, q);
    read_burst(50, 0);
    idle_cycle();

    // Full-depth burst touches every location once
    rand_data(q, DEPTH);
    write_burst(17, DEPTH - 1, 2, q);
    read_burst(17, DEPTH - 1);
    idle_cycle();

    for (int n = 0; n < 24; n++) begin
      int a, len;
      a   = $urandom_range(0, DEPTH - 1);
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(0, DEPTH - 1) : $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) idle_cycle();
      if ($urandom_range(0, 1) == 1) begin
        rand_data(q, len + 1);
        write_burst(a, len, 2, q);
      end else begin
        read_burst(a, len);
      end
    end
    idle_cycle();
    idle_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
